// File: rtl/gf2_encode_seq_ctrl.sv
// Systematic GF(2) encoder sequencer: walks K generator rows from a 1-cycle ROM,
// accumulates message-gated rows into the parity, and presents {msg, parity}.
module gf2_encode_seq_ctrl #(
  parameter int K      = 8,
  parameter int P      = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [K-1:0]      msg_in,
  input  logic              msg_valid,
  output logic              msg_ready,
  output logic              row_en,
  output logic [ADDR_W-1:0] row_addr,
  input  logic [P-1:0]      row_data,
  output logic [K+P-1:0]    cw_data,
  output logic              cw_valid,
  input  logic              cw_ready,
  output logic              busy
);

  localparam int CNT_W = $clog2(K + 1);
  localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [K-1:0]      r_msg;
  logic [P-1:0]      r_parity;
  logic              r_msg_ready;
  logic              r_row_en;
  logic [ADDR_W-1:0] r_row_addr;
  logic [K+P-1:0]    r_cw_data;
  logic              r_cw_valid;
  logic              r_busy;

  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [K-1:0]      w_sel;
  logic              w_gate;
  logic [P-1:0]      w_parity_nxt;
  logic              w_issue_nxt;

  // Row data arriving while cnt==i belongs to row i-1, gated by msg[i-1].
  assign w_cnt_nxt    = r_cnt + CNT_W'(1);
  assign w_sel        = K'(1) << (r_cnt - CNT_W'(1));
  assign w_gate       = |(r_msg & w_sel);
  assign w_parity_nxt = r_parity ^ ({P{w_gate}} & row_data);
  assign w_issue_nxt  = (w_cnt_nxt < K_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_msg       <= '0;
      r_parity    <= '0;
      r_msg_ready <= 1'b0;
      r_row_en    <= 1'b0;
      r_row_addr  <= '0;
      r_cw_data   <= '0;
      r_cw_valid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_msg_ready <= 1'b1;
          if (msg_valid && r_msg_ready) begin
            r_msg       <= msg_in;
            r_parity    <= '0;
            r_cnt       <= '0;
            r_state     <= S_RUN;
            r_msg_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_row_en    <= 1'b1;
            r_row_addr  <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= w_cnt_nxt;
          if (r_cnt != '0) r_parity <= w_parity_nxt;
          if (r_cnt == K_CNT) begin
            r_state    <= S_OUT;
            r_cw_valid <= 1'b1;
            r_cw_data  <= {r_msg, w_parity_nxt};
            r_row_en   <= 1'b0;
            r_row_addr <= '0;
          end else begin
            r_row_en   <= w_issue_nxt;
            r_row_addr <= w_issue_nxt ? ADDR_W'(w_cnt_nxt) : '0;
          end
        end
        S_OUT: begin
          if (cw_ready) begin
            r_state     <= S_IDLE;
            r_cw_valid  <= 1'b0;
            r_cw_data   <= '0;
            r_busy      <= 1'b0;
            r_msg_ready <= 1'b1;
            r_cnt       <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign msg_ready = r_msg_ready;
  assign row_en    = r_row_en;
  assign row_addr  = r_row_addr;
  assign cw_data   = r_cw_data;
  assign cw_valid  = r_cw_valid;
  assign busy      = r_busy;

endmodule

// File: doc/gf2_encode_seq_ctrl.md
Name: gf2_encode_seq_ctrl

Overview:
- Sequencer for the GF(2) multiply-accumulate stage cells (w = w0 XOR (si AND f)) that form the systematic encoder parity path.
- Accepts one K-bit message and walks the generator-matrix rows held in an external synchronous ROM, one row per cycle.
- For each row i, conditionally XORs the row into a P-bit parity accumulator, gated by message bit i.
- Presents the codeword {msg, parity} on a valid/ready output.

Parameters:
- K, 8, message length in bits (= number of generator rows).
- P, 8, parity length in bits (= row width).
- ADDR_W, 3, row address width; must satisfy 2^ADDR_W >= K.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- msg_in  in  K  message word; msg_in[i] gates generator row i.
- msg_valid  in  1  message offered.
- msg_ready  out  1  block can accept a message.
- row_en  out  1  ROM read enable.
- row_addr  out  ADDR_W  ROM row address.
- row_data  in  P  ROM data; valid exactly 1 cycle after row_en.
- cw_data  out  K+P  codeword: [K+P-1:P] = message, [P-1:0] = parity.
- cw_valid  out  1  codeword available.
- cw_ready  in  1  downstream accepts codeword.
- busy  out  1  high in RUN or OUT.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, cnt=0, parity=0, msg register=0.
  - msg_ready=0 while rst_n is low; msg_ready=1 from the first cycle after rst_n deasserts.
  - row_en=0, row_addr=0, cw_valid=0, cw_data=0, busy=0.
- States: IDLE, RUN, OUT.
- IDLE:
  - msg_ready=1.
  - On msg_valid&&msg_ready at edge E0: latch msg_in, clear parity, cnt<=0, go RUN.
- RUN:
  - Counter cnt has clog2(K+1) bits.
  - Issue: row_en = (cnt<K); row_addr = cnt[ADDR_W-1:0] when row_en=1, else 0.
  - Accumulate: when cnt>=1, parity <= parity ^ ({P{msg[cnt-1]}} & row_data) at the edge.
  - cnt increments every cycle.
  - At the edge where cnt==K (final accumulate of row K-1), go OUT.
  - RUN lasts exactly K+1 cycles. Every row is fetched even when its message bit is 0.
- OUT:
  - cw_valid=1; cw_data={msg, parity}, held stable until cw_ready.
  - On cw_valid&&cw_ready: go IDLE and drop cw_valid.
- Latency: cw_valid rises K+1 edges after the accept edge E0 (E0+K+1). A new message can be accepted no earlier than the cycle after the codeword handshake (no overlap).
- msg_valid is ignored outside IDLE. msg_in may change after acceptance without effect.
- busy=1 in RUN and OUT; msg_ready=0 in RUN and OUT.
- cw_data is 0 outside OUT.
- Async reset mid-RUN or mid-OUT:
  - Everything returns to reset values immediately; the partial parity is discarded.
  - The next accepted message encodes from a clean accumulator.
- Arithmetic is pure GF(2): AND for multiply, XOR for add. There are no carries.
- row_data is sampled only in RUN with cnt>=1; it is don't-care otherwise.

Test Plan (K=8, P=8, 1-cycle ROM model):
1. Identity ROM (row i = 8'h01<<i), msg_in=8'hA5 -> exactly 8 row_en pulses at addresses 0..7; cw_valid at E0+9; cw_data=16'hA5A5.
2. All-ones ROM (every row 8'hFF), msg_in=8'h07 -> parity=8'hFF (odd weight), cw_data=16'h07FF. Then msg_in=8'h03 -> cw_data=16'h0300.
3. msg_in=8'h00 with any ROM -> 8 row_en pulses still issued, cw_data=16'h0000, same latency of 9 edges.
4. Backpressure: hold cw_ready=0 for 5 cycles in OUT with msg_valid=1 -> cw_data stable, cw_valid=1, msg_ready=0. Raise cw_ready -> handshake, IDLE next cycle, next message accepted.
5. Reset mid-RUN: assert rst_n=0 at cnt=4 -> all outputs at reset values asynchronously. After release, msg_in=8'hA5 on the identity ROM -> 16'hA5A5 (no stale parity).
6. Back-to-back: msg_valid held high with two messages (8'h01, 8'h80) on the identity ROM -> cw 16'h0101 then 16'h8080; second accept exactly one cycle after the first cw handshake.
